spram_bank_array: RTL

//  Parametrised data memory built from SB_SPRAM256KA primitives: NUM_BANKS banks, each

---
 rtl/spram_bank_array.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spram_bank_array.sv
// Banked data memory modelled on SB_SPRAM256KA lanes (16K x 16 each), with valid/ready
// requests, byte enables and a 1-cycle read response. Define SPRAM_BANK_PWR_EN for idle standby.
module spram_bank_array #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 3,
  localparam int unsigned ADDR_WIDTH = 14 + $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [NUM_BANKS-1:0]    bank_active
);

  localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned Nibs  = DATA_WIDTH / 4;
  localparam int unsigned Rows  = 16384;

  logic [BankW-1:0]     bank_sel;
  logic [13:0]          row;
  logic [NUM_BANKS-1:0] hit, cs, standby;
  logic [Nibs-1:0]      maskwren;
  logic                 accept;

  assign row = req_addr[13:0];

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank_sel = req_addr[ADDR_WIDTH-1:14];
  end else begin : g_bank_sel_one
    assign bank_sel = '0;
  end

  // Each byte enable drives the two nibble write masks of its lane.
  always_comb begin
    maskwren = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      maskwren[2*b]   = req_be[b];
      maskwren[2*b+1] = req_be[b];
    end
  end

  always_comb begin
    hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hit[b] = (bank_sel == BankW'(b));
    end
  end

  assign req_ready = |(hit & bank_active);
  assign accept    = req_valid & req_ready;
  assign cs        = hit & bank_active & {NUM_BANKS{req_valid}};

  // Storage and per-bank output registers, as the SPRAM primitives provide them.
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][Rows];
  logic [DATA_WIDTH-1:0] dout_q [NUM_BANKS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cs[b] && !standby[b]) begin
        if (req_we) begin
          for (int n = 0; n < Nibs; n++) begin
            if (maskwren[n]) mem[b][row][n*4 +: 4] <= req_wdata[n*4 +: 4];
          end
        end else begin
          dout_q[b] <= mem[b][row];
        end
      end
    end
  end

  logic             rsp_valid_q, rd_seen_q;
  logic [BankW-1:0] rd_bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rd_seen_q   <= 1'b0;
      rd_bank_q   <= '0;
    end else begin
      rsp_valid_q <= accept & ~req_we;
      if (accept && !req_we) begin
        rd_seen_q <= 1'b1;
        rd_bank_q <= bank_sel;
      end
    end
  end

  // rd_seen_q keeps the output at zero until the first read after reset.
  always_comb begin
    rsp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_seen_q && rd_bank_q == BankW'(b)) rsp_rdata = dout_q[b];
    end
  end

  assign rsp_valid = rsp_valid_q;

`ifdef SPRAM_BANK_PWR_EN
  localparam int unsigned CntW  = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {StActive, StStandby, StWake} bank_state_e;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_pwr
    bank_state_e      state_q;
    logic [CntW-1:0]  idle_q;
    logic [WakeW-1:0] wake_q;
    logic             active_q, standby_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StActive;
        idle_q    <= '0;
        wake_q    <= '0;
        active_q  <= 1'b1;
        standby_q <= 1'b0;
      end else begin
        unique case (state_q)
          StActive: begin
            // An access on the threshold cycle clears the counter instead of sleeping.
            if (cs[g]) begin
              idle_q <= '0;
            end else if (idle_q >= CntW'(IDLE_CYCLES - 1)) begin
              idle_q    <= CntW'(IDLE_CYCLES);
              state_q   <= StStandby;
              active_q  <= 1'b0;
              standby_q <= 1'b1;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          StStandby: begin
            if (req_valid && hit[g]) begin
              state_q   <= StWake;
              wake_q    <= '0;
              standby_q <= 1'b0;
            end
          end
          StWake: begin
            if (wake_q == WakeW'(WAKE_CYCLES - 1)) begin
              state_q  <= StActive;
              active_q <= 1'b1;
              idle_q   <= '0;
            end else begin
              wake_q <= wake_q + 1'b1;
            end
          end
          default: begin
            state_q   <= StActive;
            active_q  <= 1'b1;
            standby_q <= 1'b0;
          end
        endcase
      end
    end

    assign bank_active[g] = active_q;
    assign standby[g]     = standby_q;
  end
`else
  assign bank_active = '1;
  assign standby     = '0;
`endif

endmodule
